pattern_serializer: RTL and testbench
=====================================

# pattern_serializer

Upstream stimulus stage for the serial sequence-detector FSM. Loads a parallel bit pattern on a start request and shifts it out MSB-first, one bit per `DIV` clocks, presenting each bit on `serial_out` with a one-cycle `step` strobe. The detector consumes `serial_out` as its input `w` and advances on `step`. This lets a whole test sequence be played into the detector from switches, with no per-bit key presses.

## Interface
- `WIDTH`, default 16: pattern register width in bits.
- `DIV`, default 50_000_000: clocks per emitted bit (≥1); `DIV`=1 emits one bit per clock.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `pattern`  in  WIDTH  bits to send, MSB sent first; captured on accept.
- `length`  in  $clog2(WIDTH+1)  number of bits to send; captured on accept.
- `serial_out`  out  1  current bit, registered, stable between steps.
- `step`  out  1  registered one-cycle pulse; consumer samples `serial_out` at the end of this cycle.
- `busy`  out  1  high in SHIFT.
- `done`  out  1  high for exactly one cycle in DONE.
- `state`  out  2  current state, for LEDR display.

## Operation
- States: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10. Encoding 2'b11 is illegal; it returns to IDLE on the next edge with all registered outputs cleared.
- IDLE:
  - Start is accepted when `start`=1 and `length`≠0.
  - On accept: shift register ← `pattern`; remaining ← min(`length`, WIDTH); divider ← DIV-1; state ← SHIFT.
  - `start` with `length`=0 is ignored. The block stays in IDLE and never asserts `done`.
- SHIFT: one edge per clock.
  - If divider≠0: divider decrements and `step` ← 0.
  - If divider=0:
    - `step` ← 1 and `serial_out` ← sreg[WIDTH-1].
    - sreg shifts left, filling with 0.
    - remaining decrements and divider ← DIV-1.
    - If remaining was 1, state ← DONE; otherwise stay in SHIFT.
- DONE:
  - `done`=1, `busy`=0.
  - Next edge: state ← IDLE, `step` ← 0, `serial_out` ← 0.
- `start` is ignored in SHIFT and DONE. It is not queued.
- `pattern` and `length` changes after accept have no effect on the transfer in flight.
- Moore outputs: `busy`=(state==SHIFT), `done`=(state==DONE).

## Timing
- Reset values, asynchronous and immediate: state=IDLE, `serial_out`=0, `step`=0, `busy`=0, `done`=0, sreg=0, divider=0, remaining=0.
- Reset asserted mid-SHIFT aborts the transfer with no `done`. Outputs clear in the same cycle as `reset` rises.
- Accept edge is E0. Bit k (k=1..n, n = clamped length) has `step` high during the cycle following edge E0+k·DIV.
- `busy` is high from E0 through the edge that issues the last step.
- `done` is high during the same cycle as the last `step` pulse, i.e. the cycle after edge E0+n·DIV.
- The block returns to IDLE at edge E0+n·DIV+1. The earliest next accept edge is E0+n·DIV+2.
- `serial_out` holds each bit from its step edge until the next step edge, or until the DONE→IDLE edge.
- Between steps `step`=0. Two `step` pulses are never adjacent unless DIV=1.
- Divider width is $clog2(DIV) bits, minimum 1. Remaining-count width matches `length`. No overflow is possible because `length` is clamped to WIDTH.

## Test plan
- DIV=1, `pattern`=16'hD000, `length`=4, start pulse → `step` high for 4 consecutive cycles (cycles 1–4 after E0); `serial_out`=1,1,0,1; `done`=1 in cycle 4 only; state=IDLE at cycle 5.
- DIV=3, `pattern`=16'h8000, `length`=2 → steps in cycles 3 and 6; `serial_out`=1 in cycles 3–5 and 0 in cycle 6; `done` in cycle 6; `serial_out`=0 after return to IDLE.
- `length`=0 with start → remains IDLE, no `step`, no `done`. `length`=20 with `pattern`=16'hFFFF, DIV=1 → exactly 16 steps, all 1.
- Start pulsed during SHIFT, and `pattern` changed mid-transfer → both ignored; original bits and count delivered unchanged.
- `start` held high continuously, DIV=1, `length`=3 → second transfer accepted at edge E0+5; its first `step` occurs in cycle 6.
- `reset` asserted asynchronously between clock edges during SHIFT, bit 2 of 8 → all outputs 0 immediately; no `done`. After release, a fresh start delivers all 8 bits from the MSB.

Source files
------------

// File: rtl/pattern_serializer.sv
// Parallel-load, MSB-first serializer that plays a bit pattern into the
// sequence detector, one bit per DIV clocks with a one-cycle step strobe.
module pattern_serializer #(
  parameter int WIDTH = 16,
  parameter int DIV = 50_000_000,
  localparam int LW = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    length,
  output logic             serial_out,
  output logic             step,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10,
    BAD   = 2'b11
  } state_t;

  state_t           st;
  logic [WIDTH-1:0] sreg;
  logic [DW-1:0]    div;
  logic [LW-1:0]    rem;
  logic [LW-1:0]    len_clamp;

  assign len_clamp = (length > LEN_MAX) ? LEN_MAX : length;

  assign state = st;
  assign busy  = (st == SHIFT);
  assign done  = (st == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      serial_out <= 1'b0;
      step       <= 1'b0;
      sreg       <= '0;
      div        <= '0;
      rem        <= '0;
    end else begin
      case (st)
        IDLE: begin
          step <= 1'b0;
          if (start && (length != '0)) begin
            sreg <= pattern;
            rem  <= len_clamp;
            div  <= DIV_LAST;
            st   <= SHIFT;
          end
        end
        SHIFT: begin
          if (div != '0) begin
            div  <= div - DW'(1);
            step <= 1'b0;
          end else begin
            step       <= 1'b1;
            serial_out <= sreg[WIDTH-1];
            sreg       <= sreg << 1;
            rem        <= rem - LW'(1);
            div        <= DIV_LAST;
            if (rem == LW'(1))
              st <= DONE;
          end
        end
        DONE: begin
          st         <= IDLE;
          step       <= 1'b0;
          serial_out <= 1'b0;
        end
        default: begin
          // illegal encoding: recover to a clean IDLE
          st         <= IDLE;
          step       <= 1'b0;
          serial_out <= 1'b0;
          sreg       <= '0;
          div        <= '0;
          rem        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer: a DIV=1 and a DIV=3 instance
// driven side by side with hand-computed expected bit streams.
module tb_pattern_serializer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        s1_start = 1'b0;
  logic [15:0] s1_pattern = '0;
  logic [4:0]  s1_length = '0;
  logic        s1_serial, s1_step, s1_busy, s1_done;
  logic [1:0]  s1_state;

  logic        s3_start = 1'b0;
  logic [15:0] s3_pattern = '0;
  logic [4:0]  s3_length = '0;
  logic        s3_serial, s3_step, s3_busy, s3_done;
  logic [1:0]  s3_state;

  int errors = 0;
  int checks = 0;

  logic [15:0] cbits;
  int          csteps;
  int          cdone;

  always #5 clock = ~clock;

  pattern_serializer #(.WIDTH(16), .DIV(1)) dut1 (
    .clock(clock), .reset(reset), .start(s1_start),
    .pattern(s1_pattern), .length(s1_length),
    .serial_out(s1_serial), .step(s1_step), .busy(s1_busy),
    .done(s1_done), .state(s1_state)
  );

  pattern_serializer #(.WIDTH(16), .DIV(3)) dut3 (
    .clock(clock), .reset(reset), .start(s3_start),
    .pattern(s3_pattern), .length(s3_length),
    .serial_out(s3_serial), .step(s3_step), .busy(s3_busy),
    .done(s3_done), .state(s3_state)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clr;
    cbits = '0;
    csteps = 0;
    cdone = 0;
  endtask

  task automatic collect1(input int n);
    repeat (n) begin
      tick();
      if (s1_step === 1'b1) begin
        cbits = {cbits[14:0], s1_serial};
        csteps++;
      end
      if (s1_done === 1'b1) cdone++;
    end
  endtask

  task automatic collect3(input int n);
    repeat (n) begin
      tick();
      if (s3_step === 1'b1) begin
        cbits = {cbits[14:0], s3_serial};
        csteps++;
      end
      if (s3_done === 1'b1) cdone++;
    end
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #2;
    checks++;
    if ({s1_state, s1_serial, s1_step, s1_busy, s1_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_dut1 got=%b exp=000000",
               {s1_state, s1_serial, s1_step, s1_busy, s1_done});
    end
    checks++;
    if ({s3_state, s3_serial, s3_step, s3_busy, s3_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_dut3 got=%b exp=000000",
               {s3_state, s3_serial, s3_step, s3_busy, s3_done});
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (s1_state !== 2'b00 || s3_state !== 2'b00) begin
      errors++;
      $display("FAIL reset_release got=%b/%b exp=00/00",
               s1_state, s3_state);
    end
  endtask

  task automatic test_div1;
    logic [3:0] exp_bits;
    exp_bits = 4'b1101;
    s1_pattern = 16'hD000;
    s1_length = 5'd4;
    s1_start = 1'b1;
    tick();
    s1_start = 1'b0;
    checks++;
    if (s1_busy !== 1'b1 || s1_step !== 1'b0) begin
      errors++;
      $display("FAIL div1_accept busy=%b step=%b exp busy=1 step=0",
               s1_busy, s1_step);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (s1_step !== 1'b1 || s1_serial !== exp_bits[4-k]
          || s1_done !== (k == 4)) begin
        errors++;
        $display("FAIL div1_bit%0d step=%b ser=%b done=%b exp 1/%b/%b",
                 k, s1_step, s1_serial, s1_done, exp_bits[4-k], k == 4);
      end
    end
    tick();
    checks++;
    if (s1_state !== 2'b00 || s1_step !== 1'b0 || s1_serial !== 1'b0) begin
      errors++;
      $display("FAIL div1_idle state=%b step=%b ser=%b exp 00/0/0",
               s1_state, s1_step, s1_serial);
    end
  endtask

  task automatic test_div3;
    logic [7:1] exp_step, exp_ser, exp_done;
    exp_step = 7'b0100100;
    exp_ser  = 7'b0011100;
    exp_done = 7'b0100000;
    s3_pattern = 16'h8000;
    s3_length = 5'd2;
    s3_start = 1'b1;
    tick();
    s3_start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      checks++;
      if (s3_step !== exp_step[c] || s3_serial !== exp_ser[c]
          || s3_done !== exp_done[c]) begin
        errors++;
        $display("FAIL div3_cyc%0d step=%b ser=%b done=%b exp %b/%b/%b",
                 c, s3_step, s3_serial, s3_done,
                 exp_step[c], exp_ser[c], exp_done[c]);
      end
    end
    checks++;
    if (s3_state !== 2'b00) begin
      errors++;
      $display("FAIL div3_idle state=%b exp=00", s3_state);
    end
  endtask

  task automatic test_length_bounds;
    s1_pattern = 16'hFFFF;
    s1_length = 5'd0;
    s1_start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (s1_state !== 2'b00 || s1_step !== 1'b0 || s1_done !== 1'b0) begin
        errors++;
        $display("FAIL len0_cyc%0d state=%b step=%b done=%b exp 00/0/0",
                 c, s1_state, s1_step, s1_done);
      end
    end
    s1_length = 5'd20;
    tick();
    s1_start = 1'b0;
    clr();
    collect1(20);
    checks++;
    if (csteps != 16 || cbits !== 16'hFFFF || cdone != 1) begin
      errors++;
      $display("FAIL len20_clamp steps=%0d bits=%h done=%0d exp 16/ffff/1",
               csteps, cbits, cdone);
    end
    checks++;
    if (s1_state !== 2'b00) begin
      errors++;
      $display("FAIL len20_idle state=%b exp=00", s1_state);
    end
  endtask

  task automatic test_ignore_inputs;
    s3_pattern = 16'hA500;
    s3_length = 5'd8;
    s3_start = 1'b1;
    tick();
    s3_start = 1'b0;
    clr();
    collect3(4);
    s3_pattern = 16'h0000;
    s3_length = 5'd1;
    s3_start = 1'b1;
    collect3(1);
    s3_start = 1'b0;
    collect3(22);
    checks++;
    if (csteps != 8 || cbits !== 16'h00A5 || cdone != 1) begin
      errors++;
      $display("FAIL ignore_mid steps=%0d bits=%h done=%0d exp 8/00a5/1",
               csteps, cbits, cdone);
    end
    checks++;
    if (s3_state !== 2'b00) begin
      errors++;
      $display("FAIL ignore_idle state=%b exp=00", s3_state);
    end
  endtask

  task automatic test_back_to_back;
    s1_pattern = 16'hA000;
    s1_length = 5'd3;
    s1_start = 1'b1;
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (s1_done !== 1'b1 || s1_step !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done done=%b step=%b exp 1/1", s1_done, s1_step);
    end
    tick();
    checks++;
    if (s1_state !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle state=%b exp=00", s1_state);
    end
    tick();
    checks++;
    if (s1_busy !== 1'b1 || s1_step !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept busy=%b step=%b exp 1/0", s1_busy, s1_step);
    end
    tick();
    checks++;
    if (s1_step !== 1'b1 || s1_serial !== 1'b1) begin
      errors++;
      $display("FAIL b2b_step1 step=%b ser=%b exp 1/1", s1_step, s1_serial);
    end
    s1_start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (s1_state !== 2'b00 || s1_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end state=%b busy=%b exp 00/0", s1_state, s1_busy);
    end
  endtask

  task automatic test_async_reset;
    s3_pattern = 16'hC300;
    s3_length = 5'd8;
    s3_start = 1'b1;
    tick();
    s3_start = 1'b0;
    clr();
    collect3(4);
    checks++;
    if (csteps != 1 || s3_serial !== 1'b1 || s3_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre steps=%0d ser=%b busy=%b exp 1/1/1",
               csteps, s3_serial, s3_busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({s3_state, s3_serial, s3_step, s3_busy, s3_done} !== 6'b0) begin
      errors++;
      $display("FAIL rst_async got=%b exp=000000",
               {s3_state, s3_serial, s3_step, s3_busy, s3_done});
    end
    tick();
    reset = 1'b0;
    clr();
    collect3(10);
    checks++;
    if (csteps != 0 || cdone != 0 || s3_state !== 2'b00) begin
      errors++;
      $display("FAIL rst_abort steps=%0d done=%0d state=%b exp 0/0/00",
               csteps, cdone, s3_state);
    end
    s3_start = 1'b1;
    tick();
    s3_start = 1'b0;
    clr();
    collect3(27);
    checks++;
    if (csteps != 8 || cbits !== 16'h00C3 || cdone != 1) begin
      errors++;
      $display("FAIL rst_fresh steps=%0d bits=%h done=%0d exp 8/00c3/1",
               csteps, cbits, cdone);
    end
  endtask

  initial begin
    test_reset();
    test_div1();
    test_div3();
    test_length_bounds();
    test_ignore_inputs();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
